deal_scheduler: RTL and testbench

DEAL_SCHEDULER -- requirements
Module: deal_scheduler

---
 rtl/deal_scheduler.sv | 158 +++++++++++++++
 tb/tb_deal_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_scheduler.sv
// Card-deal sequencer: walks a two-hand, third-card-rule deal one advance at a time.
// It drives datapath load strobes, shows the round outcome and keeps saturating win/tie tallies.
module deal_scheduler #(
  parameter int unsigned AUTO_DELAY = 50000000
) (
  input  logic       fast_clock,
  input  logic       reset,
  input  logic       step,
  input  logic       auto_en,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_hand,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       busy,
  output logic [7:0] player_wins,
  output logic [7:0] dealer_wins,
  output logic [7:0] ties
);

  localparam int TW = (AUTO_DELAY > 1) ? $clog2(AUTO_DELAY) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_DELAY - 1);

  typedef enum logic [3:0] {
    IDLE, P1, D1, P2, D2, DECIDE, BANK, D3WAIT, RESULT
  } state_t;

  typedef struct packed {
    logic clear_hand;
    logic pcard1;
    logic dcard1;
    logic pcard2;
    logic dcard2;
    logic pcard3;
    logic dcard3;
  } strobe_t;

  state_t         state, next_state;
  strobe_t        strobe_q, strobe_d;
  logic           step_q;
  logic [TW-1:0]  timer;
  logic           timer_done;
  logic           advance;
  logic           banker_draws;
  logic           enter_result;

  assign timer_done   = auto_en && (timer == TIMER_LAST);
  // Step edge and timer terminal count are OR-ed, so a coincidence is still a single event.
  assign advance      = (step && !step_q) || timer_done;
  assign enter_result = (next_state == RESULT) && (state != RESULT);
  assign busy         = (state != IDLE);

  always_comb begin
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pcard3 != 4'd8);
      4'd4:             banker_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             banker_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             banker_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    strobe_d   = '0;
    if (advance) begin
      case (state)
        IDLE:   begin next_state = P1;     strobe_d.clear_hand = 1'b1; end
        P1:     begin next_state = D1;     strobe_d.pcard1     = 1'b1; end
        D1:     begin next_state = P2;     strobe_d.dcard1     = 1'b1; end
        P2:     begin next_state = D2;     strobe_d.pcard2     = 1'b1; end
        D2:     begin next_state = DECIDE; strobe_d.dcard2     = 1'b1; end
        DECIDE: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            next_state = RESULT;
          end else if (pscore <= 4'd5) begin
            next_state      = BANK;
            strobe_d.pcard3 = 1'b1;
          end else if (dscore <= 4'd5) begin
            next_state      = D3WAIT;
            strobe_d.dcard3 = 1'b1;
          end else begin
            next_state = RESULT;
          end
        end
        BANK: begin
          if (banker_draws) begin
            next_state      = D3WAIT;
            strobe_d.dcard3 = 1'b1;
          end else begin
            next_state = RESULT;
          end
        end
        D3WAIT: next_state = RESULT;
        RESULT: begin next_state = P1; strobe_d.clear_hand = 1'b1; end
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state    <= IDLE;
      strobe_q <= '0;
      // NOTE: step_q resets high so a step held across reset release is not seen as an edge.
      step_q   <= 1'b1;
      timer    <= '0;
    end else begin
      state    <= next_state;
      strobe_q <= strobe_d;
      step_q   <= step;
      if (advance || !auto_en) timer <= '0;
      else                     timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      player_wins      <= '0;
      dealer_wins      <= '0;
      ties             <= '0;
    end else if (enter_result) begin
      player_win_light <= (pscore >= dscore);
      dealer_win_light <= (dscore >= pscore);
      if (pscore > dscore) begin
        if (player_wins != 8'hFF) player_wins <= player_wins + 8'd1;
      end else if (dscore > pscore) begin
        if (dealer_wins != 8'hFF) dealer_wins <= dealer_wins + 8'd1;
      end else begin
        if (ties != 8'hFF) ties <= ties + 8'd1;
      end
    end else if (advance && state == RESULT) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  end

  assign clear_hand  = strobe_q.clear_hand;
  assign load_pcard1 = strobe_q.pcard1;
  assign load_dcard1 = strobe_q.dcard1;
  assign load_pcard2 = strobe_q.pcard2;
  assign load_dcard2 = strobe_q.dcard2;
  assign load_pcard3 = strobe_q.pcard3;
  assign load_dcard3 = strobe_q.dcard3;

endmodule

// File: tb/tb_deal_scheduler.sv
// Self-checking bench for deal_scheduler: table vectors, hand-written corner sequences,
// and random rounds scored against a drawing-rule reference model.
module tb_deal_scheduler;

  localparam logic [6:0] S_NONE = 7'h00;
  localparam logic [6:0] S_CLR  = 7'h40;
  localparam logic [6:0] S_P1   = 7'h20;
  localparam logic [6:0] S_D1   = 7'h10;
  localparam logic [6:0] S_P2   = 7'h08;
  localparam logic [6:0] S_D2   = 7'h04;
  localparam logic [6:0] S_P3   = 7'h02;
  localparam logic [6:0] S_D3   = 7'h01;

  logic       fast_clock = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clear_hand, player_win_light, dealer_win_light, busy;
  logic [7:0] player_wins, dealer_wins, ties;
  logic [6:0] strobes;

  int tests = 0;
  int fails = 0;
  int m_pw = 0, m_dw = 0, m_tie = 0;

  typedef struct {
    logic [3:0] p;
    logic [3:0] d;
    logic [3:0] c3;
    int         n;
    logic [6:0] s0, s1, s2;
    logic       pl, dl;
  } vec_t;

  vec_t vecs[12];

  deal_scheduler #(.AUTO_DELAY(4)) dut (
    .fast_clock(fast_clock), .reset(reset), .step(step), .auto_en(auto_en),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .clear_hand(clear_hand), .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light), .busy(busy),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
  );

  assign strobes = {clear_hand, load_pcard1, load_dcard1, load_pcard2,
                    load_dcard2, load_pcard3, load_dcard3};

  always #5 fast_clock = ~fast_clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  // One manual advance: strobe appears the cycle after the edge, and lasts one cycle.
  task automatic adv(input logic [6:0] exp, input string name);
    step = 1'b1;
    tick();
    check(name, {25'd0, strobes}, {25'd0, exp});
    step = 1'b0;
    tick();
    check({name, "_drop"}, {25'd0, strobes}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_pw = 0; m_dw = 0; m_tie = 0;
  endtask

  function automatic bit bank_draws(input int d, input int c);
    if (d <= 2) return 1'b1;
    if (d == 3) return c != 8;
    if (d == 4) return c >= 2 && c <= 7;
    if (d == 5) return c >= 4 && c <= 7;
    if (d == 6) return c >= 6 && c <= 7;
    return 1'b0;
  endfunction

  // Strobes expected for each advance starting at the decision point, ending in RESULT.
  task automatic plan(input int p, input int d, input int c, output int n,
                      output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
    s0 = S_NONE; s1 = S_NONE; s2 = S_NONE; n = 1;
    if (p >= 8 || d >= 8) n = 1;
    else if (p <= 5) begin
      s0 = S_P3;
      if (bank_draws(d, c)) begin n = 3; s1 = S_D3; end
      else n = 2;
    end else if (d <= 5) begin n = 2; s0 = S_D3; end
  endtask

  task automatic score_round(input int p, input int d);
    if (p > d)      m_pw  = (m_pw  < 255) ? m_pw + 1  : 255;
    else if (d > p) m_dw  = (m_dw  < 255) ? m_dw + 1  : 255;
    else            m_tie = (m_tie < 255) ? m_tie + 1 : 255;
  endtask

  task automatic check_result(input string name, input logic pl, input logic dl);
    check({name, "_plight"}, {31'd0, player_win_light}, {31'd0, pl});
    check({name, "_dlight"}, {31'd0, dealer_win_light}, {31'd0, dl});
    check({name, "_pwins"}, {24'd0, player_wins}, m_pw);
    check({name, "_dwins"}, {24'd0, dealer_wins}, m_dw);
    check({name, "_ties"}, {24'd0, ties}, m_tie);
  endtask

  task automatic deal_prefix(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c);
    pscore = p; dscore = d; pcard3 = c;
    adv(S_CLR, "clear");
    check("lights_cleared", {30'd0, player_win_light, dealer_win_light}, 32'd0);
    check("busy_in_round", {31'd0, busy}, 32'd1);
    adv(S_P1, "pcard1");
    adv(S_D1, "dcard1");
    adv(S_P2, "pcard2");
    adv(S_D2, "dcard2");
  endtask

  task automatic model_round(input int p, input int d, input int c, input string name);
    int n;
    logic [6:0] s[3];
    deal_prefix(4'(p), 4'(d), 4'(c));
    plan(p, d, c, n, s[0], s[1], s[2]);
    for (int i = 0; i < n; i++) adv(s[i], name);
    score_round(p, d);
    check_result(name, p >= d, d >= p);
  endtask

  initial begin
    vecs[0]  = '{4'd9, 4'd3, 4'd0, 1, S_NONE, S_NONE, S_NONE, 1'b1, 1'b0};
    vecs[1]  = '{4'd7, 4'd7, 4'd0, 1, S_NONE, S_NONE, S_NONE, 1'b1, 1'b1};
    vecs[2]  = '{4'd4, 4'd5, 4'd4, 3, S_P3,   S_D3,   S_NONE, 1'b0, 1'b1};
    vecs[3]  = '{4'd5, 4'd6, 4'd6, 3, S_P3,   S_D3,   S_NONE, 1'b0, 1'b1};
    vecs[4]  = '{4'd5, 4'd6, 4'd5, 2, S_P3,   S_NONE, S_NONE, 1'b0, 1'b1};
    vecs[5]  = '{4'd3, 4'd3, 4'd8, 2, S_P3,   S_NONE, S_NONE, 1'b1, 1'b1};
    vecs[6]  = '{4'd2, 4'd4, 4'd1, 2, S_P3,   S_NONE, S_NONE, 1'b0, 1'b1};
    vecs[7]  = '{4'd6, 4'd5, 4'd0, 2, S_D3,   S_NONE, S_NONE, 1'b1, 1'b0};
    vecs[8]  = '{4'd6, 4'd6, 4'd0, 1, S_NONE, S_NONE, S_NONE, 1'b1, 1'b1};
    vecs[9]  = '{4'd0, 4'd8, 4'd0, 1, S_NONE, S_NONE, S_NONE, 1'b0, 1'b1};
    vecs[10] = '{4'd1, 4'd7, 4'd7, 2, S_P3,   S_NONE, S_NONE, 1'b0, 1'b1};
    vecs[11] = '{4'd5, 4'd2, 4'd0, 3, S_P3,   S_D3,   S_NONE, 1'b1, 1'b0};

    do_reset();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_strobes", {25'd0, strobes}, 32'd0);
    check("reset_tallies", {8'd0, player_wins, dealer_wins, ties}, 32'd0);

    // Table vectors: expectations are hand-derived constants.
    for (int i = 0; i < 12; i++) begin
      logic [6:0] s[3];
      s[0] = vecs[i].s0; s[1] = vecs[i].s1; s[2] = vecs[i].s2;
      deal_prefix(vecs[i].p, vecs[i].d, vecs[i].c3);
      for (int k = 0; k < vecs[i].n; k++) adv(s[k], $sformatf("vec%0d_s%0d", i, k));
      score_round(vecs[i].p, vecs[i].d);
      check_result($sformatf("vec%0d", i), vecs[i].pl, vecs[i].dl);
      tick();
      check($sformatf("vec%0d_hold", i), {30'd0, player_win_light, dealer_win_light},
            {30'd0, vecs[i].pl, vecs[i].dl});
    end

    // Scores are sampled at the advance into RESULT, not earlier.
    deal_prefix(4'd4, 4'd5, 4'd4);
    adv(S_P3, "late_p3");
    adv(S_D3, "late_d3");
    pscore = 4'd4; dscore = 4'd7;
    adv(S_NONE, "late_result");
    score_round(4, 7);
    check_result("late", 1'b0, 1'b1);

    // Reset inside BANK with step held high, then release with step still high.
    deal_prefix(4'd4, 4'd5, 4'd4);
    adv(S_P3, "to_bank");
    step = 1'b1;
    reset = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {25'd0, strobes}, 32'd0);
    check("rst_lights", {30'd0, player_win_light, dealer_win_light}, 32'd0);
    check("rst_tallies", {8'd0, player_wins, dealer_wins, ties}, 32'd0);
    m_pw = 0; m_dw = 0; m_tie = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_step_no_event", {24'd0, strobes, busy}, 32'd0);
    end
    step = 1'b0;
    tick();
    adv(S_CLR, "rearm_clear");
    check("rearm_busy", {31'd0, busy}, 32'd1);

    // Automatic advance timer with AUTO_DELAY=4.
    do_reset();
    pscore = 4'd9; dscore = 4'd0;
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("auto_wait0", {25'd0, strobes}, 32'd0); end
    tick(); check("auto_clear", {25'd0, strobes}, {25'd0, S_CLR});
    tick();
    step = 1'b1;
    tick(); check("mid_step_p1", {25'd0, strobes}, {25'd0, S_P1});
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); check("restart_wait", {25'd0, strobes}, 32'd0); end
    tick(); check("auto_d1", {25'd0, strobes}, {25'd0, S_D1});
    for (int i = 0; i < 3; i++) begin tick(); check("auto_wait1", {25'd0, strobes}, 32'd0); end
    step = 1'b1;
    tick(); check("coincident_p2", {25'd0, strobes}, {25'd0, S_P2});
    for (int i = 0; i < 3; i++) begin tick(); check("coinc_single", {25'd0, strobes}, 32'd0); end
    tick(); check("auto_d2", {25'd0, strobes}, {25'd0, S_D2});
    auto_en = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); check("auto_off", {25'd0, strobes}, 32'd0); end

    // Random rounds against the reference model.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      model_round($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                  $sformatf("rnd%0d", r));
    end

    // Player tally saturation.
    for (int r = 0; r < 260; r++) model_round(9, 0, 0, "sat");
    check("sat_pwins", {24'd0, player_wins}, 32'd255);
    check("sat_others", {16'd0, dealer_wins, ties}, {16'd0, 8'(m_dw), 8'(m_tie)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
